// File: rtl/arp_wavetable_ctrl_if.sv
// Control bus of the wavetable sequencer: arpeggiator button and pitch switches in,
// BRAM read address, sample strobe and note/mode status out.
interface arp_wavetable_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              arp_toggle;
    logic [7:0]        sw;
    logic [ADDR_W-1:0] addra;
    logic              sample_stb;
    logic [1:0]        note_idx;
    logic              arp_on;

    modport master (
        output arp_toggle,
        output sw,
        input  addra,
        input  sample_stb,
        input  note_idx,
        input  arp_on
    );

    modport slave (
        input  arp_toggle,
        input  sw,
        output addra,
        output sample_stb,
        output note_idx,
        output arp_on
    );
endinterface

// File: rtl/arp_wavetable_ctrl.sv
// Wavetable address sequencer with optional arpeggiator (root/M3/P5/octave chord notes).
// Define ARP_UPDOWN_EN for a ping-pong arpeggio instead of an ascending wrap.
module arp_wavetable_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned BASE_OFFSET = 261,
    parameter int unsigned NOTE_HOLD   = 50_000_000,
    parameter int unsigned DIV_W       = 13
) (
    input logic                  CLK100MHZ,
    input logic                  RST,
    arp_wavetable_ctrl_if.slave  bus
);

    localparam int unsigned HoldW = $clog2(NOTE_HOLD);

    typedef enum logic [0:0] {StRoot, StArp} mode_e;

    mode_e              mode_q, mode_d;
    logic [1:0]         note_q, note_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               stb_q, stb_d;
`ifdef ARP_UPDOWN_EN
    logic               dir_down_q, dir_down_d;
`endif

    logic [10:0]        base_p;
    logic [8:0]         k_mult;
    logic [18:0]        prod;
    logic [DIV_W-1:0]   period_next;
    logic               wrap;
    logic               hold_tc;

    // Chord ratios in Q8: 1, 4/5, 2/3, 1/2 of the period (frequency up by 5/4, 3/2, 2).
    always_comb begin
        unique case (note_q)
            2'd0:    k_mult = 9'd256;
            2'd1:    k_mult = 9'd205;
            2'd2:    k_mult = 9'd171;
            default: k_mult = 9'd128;
        endcase
    end

    assign base_p      = 11'((BASE_OFFSET + 32'(bus.sw)) << 1);
    assign prod        = 19'(base_p) * 19'(k_mult);
    assign period_next = DIV_W'(prod >> 8);
    assign wrap        = (div_q == period_q - DIV_W'(1));
    assign hold_tc     = (hold_q == HoldW'(NOTE_HOLD - 1));

    always_comb begin
        div_d    = wrap ? '0 : div_q + DIV_W'(1);
        addr_d   = wrap ? addr_q + ADDR_W'(1) : addr_q;
        // Latching only at wrap keeps the step in progress at its original length.
        period_d = wrap ? period_next : period_q;
        stb_d    = wrap;

        mode_d   = mode_q;
        note_d   = note_q;
        hold_d   = '0;
`ifdef ARP_UPDOWN_EN
        dir_down_d = dir_down_q;
`endif

        unique case (mode_q)
            StRoot: begin
                note_d = 2'd0;
                if (bus.arp_toggle) begin
                    mode_d = StArp;
`ifdef ARP_UPDOWN_EN
                    dir_down_d = 1'b0;
`endif
                end
            end
            StArp: begin
                if (bus.arp_toggle) begin
                    mode_d = StRoot;
                    note_d = 2'd0;
`ifdef ARP_UPDOWN_EN
                    dir_down_d = 1'b0;
`endif
                end else if (hold_tc) begin
`ifdef ARP_UPDOWN_EN
                    if (!dir_down_q) begin
                        if (note_q == 2'd3) begin
                            note_d     = 2'd2;
                            dir_down_d = 1'b1;
                        end else begin
                            note_d = note_q + 2'd1;
                        end
                    end else begin
                        if (note_q == 2'd0) begin
                            note_d     = 2'd1;
                            dir_down_d = 1'b0;
                        end else begin
                            note_d = note_q - 2'd1;
                        end
                    end
`else
                    note_d = note_q + 2'd1;
`endif
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: mode_d = StRoot;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            mode_q     <= StRoot;
            note_q     <= 2'd0;
            hold_q     <= '0;
            div_q      <= '0;
            period_q   <= DIV_W'(2 * BASE_OFFSET);
            addr_q     <= '0;
            stb_q      <= 1'b0;
`ifdef ARP_UPDOWN_EN
            dir_down_q <= 1'b0;
`endif
        end else begin
            mode_q     <= mode_d;
            note_q     <= note_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            period_q   <= period_d;
            addr_q     <= addr_d;
            stb_q      <= stb_d;
`ifdef ARP_UPDOWN_EN
            dir_down_q <= dir_down_d;
`endif
        end
    end

    assign bus.addra      = addr_q;
    assign bus.sample_stb = stb_q;
    assign bus.note_idx   = note_q;
    assign bus.arp_on     = (mode_q == StArp);

endmodule

// File: tb/tb_arp_wavetable_ctrl.sv
// Bench for arp_wavetable_ctrl: directed spacing/boundary checks plus a random phase,
// all outputs compared every cycle against a strobe-schedule / elapsed-time model.
module tb_arp_wavetable_ctrl;

    localparam int unsigned AW   = 5;
    localparam int unsigned HOLD = 2000;
    localparam int unsigned BASE = 261;
    localparam int          LIM  = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arp_wavetable_ctrl_if #(.ADDR_W(AW)) bus ();

    arp_wavetable_ctrl #(
        .ADDR_W     (AW),
        .BASE_OFFSET(BASE),
        .NOTE_HOLD  (HOLD),
        .DIV_W      (13)
    ) dut (
        .CLK100MHZ(clk),
        .RST      (rst),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int k_of(input int note);
        case (note)
            0:       return 256;
            1:       return 205;
            2:       return 171;
            default: return 128;
        endcase
    endfunction

    function automatic int period_of(input int sw, input int note);
        return ((2 * (BASE + sw)) * k_of(note)) >> 8;
    endfunction

    // Note held after i complete hold intervals in arpeggio mode.
    function automatic int note_at(input longint i);
`ifdef ARP_UPDOWN_EN
        int pp [6] = '{0, 1, 2, 3, 2, 1};
        return pp[int'(i % 6)];
`else
        return int'(i % 4);
`endif
    endfunction

    // Model: next strobe is scheduled by edge number; note follows elapsed time in ARP.
    longint edge_n   = 0;
    longint due      = 0;
    longint arp_edge = 0;
    bit     m_valid  = 1'b0;
    int     m_addr   = 0;
    int     m_note   = 0;
    int     m_stb    = 0;
    int     m_arp    = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b1;
                m_addr  = 0;
                m_stb   = 0;
                m_arp   = 0;
                m_note  = 0;
                due     = edge_n + 2 * BASE;
            end else if (m_valid) begin
                m_stb = (edge_n == due) ? 1 : 0;
                if (m_stb == 1) begin
                    m_addr = (m_addr + 1) % (1 << AW);
                    due    = edge_n + period_of(int'(bus.sw), m_note);
                end
                if (bus.arp_toggle) begin
                    m_arp    = 1 - m_arp;
                    arp_edge = edge_n;
                    m_note   = 0;
                end else if (m_arp == 1) begin
                    m_note = note_at((edge_n - arp_edge) / HOLD);
                end
            end
            edge_n++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("addra", 32'(bus.addra), m_addr);
                check("sample_stb", 32'(bus.sample_stb), m_stb);
                check("note_idx", 32'(bus.note_idx), m_note);
                check("arp_on", 32'(bus.arp_on), m_arp);
            end
        end
    end

    task automatic sync_stb(input string name);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.sample_stb !== 1'b1 && c < LIM);
        if (bus.sample_stb !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no sample_stb within %0d cycles", name, LIM);
        end
    endtask

    // Counts cycles from the current point to the next strobe; optionally changes sw mid-step.
    task automatic interval(input string name, input int exp, input int chg_at, input int chg_sw);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == chg_at) bus.sw = 8'(chg_sw);
        end while (bus.sample_stb !== 1'b1 && c < LIM);
        check(name, c, exp);
    endtask

    task automatic wait_note(input int v);
        int c = 0;
        while (bus.note_idx !== 2'(v) && c < 3 * HOLD) begin
            @(negedge clk);
            c++;
        end
        if (bus.note_idx !== 2'(v)) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_note: got %0d expected %0d", bus.note_idx, v);
        end
    endtask

    task automatic wait_change(input string name, input int exp);
        logic [1:0] prev = bus.note_idx;
        int c = 0;
        while (bus.note_idx === prev && c < 2 * HOLD + 10) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(bus.note_idx), exp);
    endtask

    task automatic pulse_toggle();
        bus.arp_toggle = 1'b1;
        @(negedge clk);
        bus.arp_toggle = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [6];
`ifdef ARP_UPDOWN_EN
        seq = '{1, 2, 3, 2, 1, 0};
`else
        seq = '{1, 2, 3, 0, 1, 2};
`endif
        rst            = 1'b1;
        bus.arp_toggle = 1'b0;
        bus.sw         = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Root mode, sw=0: 522-cycle steps; the address wraps after 2^AW strobes.
        interval("rst_first", 522, -1, 0);
        check("addr_first", 32'(bus.addra), 1);
        for (int i = 1; i < (1 << AW); i++) interval("root_step", 522, -1, 0);
        check("addr_wrap", 32'(bus.addra), 0);

        // sw change mid-step: current step unaffected, new period from the following step.
        interval("sw_mid", 522, 100, 255);
        interval("sw_new", 1032, -1, 0);
        bus.sw = 8'd0;
        interval("sw_back_cur", 1032, -1, 0);
        interval("sw_back_new", 522, -1, 0);

        // Arpeggio, sw=0.
        pulse_toggle();
        check("arp_on_set", 32'(bus.arp_on), 1);
        check("note_start", 32'(bus.note_idx), 0);
        wait_note(1); sync_stb("s1"); interval("arp0_n1", 418, -1, 0);
        wait_note(2); sync_stb("s2"); interval("arp0_n2", 348, -1, 0);
        wait_note(3); sync_stb("s3"); interval("arp0_n3", 261, -1, 0);

        // Reset mid-operation.
        do_reset();
        check("rst_addra", 32'(bus.addra), 0);
        check("rst_stb", 32'(bus.sample_stb), 0);
        check("rst_note", 32'(bus.note_idx), 0);
        check("rst_arp", 32'(bus.arp_on), 0);
        interval("rst_resume", 522, -1, 0);

        // Arpeggio, sw=255.
        bus.sw = 8'd255;
        pulse_toggle();
        sync_stb("t0"); interval("arp255_n0", 1032, -1, 0);
        wait_note(1); sync_stb("t1"); interval("arp255_n1", 826, -1, 0);
        wait_note(2); sync_stb("t2"); interval("arp255_n2", 689, -1, 0);
        wait_note(3); sync_stb("t3"); interval("arp255_n3", 516, -1, 0);
        pulse_toggle();
        check("arp_off", 32'(bus.arp_on), 0);

        // Toggle coinciding with the hold terminal at note 2: toggle wins.
        bus.sw = 8'd0;
        pulse_toggle();
        wait_note(2);
        repeat (HOLD - 1) @(negedge clk);
        pulse_toggle();
        check("tc_arp", 32'(bus.arp_on), 0);
        check("tc_note", 32'(bus.note_idx), 0);

        // Note sequence from a clean start.
        do_reset();
        pulse_toggle();
        for (int i = 0; i < 6; i++) wait_change("note_seq", seq[i]);

        // Random phase.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            bus.arp_toggle = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 399) == 0) bus.sw = 8'($urandom_range(0, 255));
            rst = ($urandom_range(0, 7999) == 0);
        end
        @(negedge clk);
        bus.arp_toggle = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arp_wavetable_ctrl.md
# arp_wavetable_ctrl

Sequencing controller for the audio wavetable path: it owns the BRAM read address and decides when it advances. The step rate is set by the switch-selected base pitch and, in arpeggiator mode, by the current chord note. It sits between the debounced arpeggiator button, the 8 switches, the 256-entry × 11-bit wavetable BRAM address port, and the status LEDs. The BRAM output feeds the PWM unchanged.

## Interface
- `ADDR_W`, 8 — wavetable address width; the table has 2^ADDR_W entries.
- `BASE_OFFSET`, 261 — base pitch term added to `sw`.
- `NOTE_HOLD`, 50_000_000 — clock cycles each arpeggio note is held; legal range ≥ 2.
- `DIV_W`, 13 — width of the sample-step divider counter and latched period.

- `CLK100MHZ` in 1 — single system clock, rising edge.
- `RST` in 1 — synchronous, active-high reset.
- `arp_toggle` in 1 — one-cycle pulse from the debouncer; flips arpeggiator mode.
- `sw` in 8 — base pitch offset, unsigned.
- `addra` out ADDR_W — BRAM read address.
- `sample_stb` out 1 — one-cycle pulse in the cycle `addra` increments.
- `note_idx` out 2 — current chord note: 0=root, 1=major third, 2=fifth, 3=octave.
- `arp_on` out 1 — 1 while arpeggiator mode is active.

## Operation
- Base period: `P = 2*(BASE_OFFSET + sw)`, 11-bit unsigned; range 522 to 1032 at defaults.
- Note period: `period_next = (P * K[note_idx]) >> 8`.
  - K = {256, 205, 171, 128}; the 19-bit product is truncated.
  - Multiply by constant only; no divider.
- Divider:
  - `div_cnt` counts 0 … `period_q`−1.
  - At `div_cnt == period_q−1`: `div_cnt` ← 0, `addra` ← `addra`+1 (wraps 2^ADDR_W−1 → 0), `sample_stb` = 1, `period_q` ← `period_next`.
  - `period_q` changes only at divider wrap, so `sw` or note changes never truncate or stretch a step in progress.
- Mode FSM, two states:
  - ROOT (`arp_on`=0): `note_idx` held at 0; hold counter held at 0.
  - ARP (`arp_on`=1): `hold_cnt` counts 0 … NOTE_HOLD−1. At terminal count it clears and `note_idx` advances 0→1→2→3→0.
- `arp_toggle` in ROOT → ARP; in ARP → ROOT. Both transitions force `note_idx` ← 0 and `hold_cnt` ← 0.
- Simultaneous events:
  - Toggle and hold terminal in the same cycle: toggle wins; `note_idx` = 0.
  - Note change and divider wrap in the same cycle: the latched period uses the pre-change `note_idx`.
- The divider and `addra` run continuously and are never reset by mode changes, so the waveform phase is continuous.

## Timing
- Reset values: `addra`=0, `sample_stb`=0, `note_idx`=0, `arp_on`=0, `div_cnt`=0, `hold_cnt`=0, `period_q`=2*BASE_OFFSET (522).
- Reset mid-operation: all of the above apply on the next edge; `arp_toggle` is ignored while `RST`=1.
- `sample_stb` spacing is exactly `period_q` cycles.
- `arp_on` and `note_idx` update one cycle after the `arp_toggle` pulse.
- A new `sw` or note value affects step spacing after the next wrap, then applies to the step that follows it.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `ARP_UPDOWN_EN` defined: ARP uses a ping-pong pattern 0,1,2,3,2,1,0,1…
  - A direction register resets to "up" and is also forced to "up" on every toggle.
- `ARP_UPDOWN_EN` undefined: ascending wrap 0,1,2,3,0…; no direction register is built.

## Test plan
1. Reset, `sw`=0, no toggle: the first `sample_stb` occurs 522 cycles after reset release, then every 522 cycles; `addra` 255→0 after 256 strobes.
2. Bench NOTE_HOLD=2000, `sw`=0, pulse `arp_toggle`: `arp_on`=1 and `note_idx` steps 0,1,2,3,0 every 2000 cycles. Strobe spacing settles to 522, 418, 348, 261 per note, each taking effect from the step after the wrap following the note change.
3. `sw`=255, ARP mode: spacings are 1032, 826, 689, 516 for `note_idx` 0–3.
4. Change `sw` 0→255 mid-step: the current step still completes at 522 cycles; 1032 applies from the step after the next wrap.
5. Pulse `arp_toggle` in the same cycle as the hold terminal while `note_idx`=2: `arp_on`=0 and `note_idx`=0, not 3. `addra` does not jump.
6. With `ARP_UPDOWN_EN`: the sequence is 0,1,2,3,2,1,0,1. Asserting `RST` at `note_idx`=3 gives all reset values on the next cycle, and `sample_stb` resumes after 522 cycles.
